r_shifter: RTL and testbench
============================

Name: r_shifter

Overview:
- Registered 11-bit logical right barrel shifter for the floating-point adder's exponent-alignment path.
- Shifts the smaller operand's mantissa right by the exponent difference.
- Reports a sticky bit, the OR of all bits shifted out, for later rounding.
- Built as four logarithmic stages (shift by 1, 2, 4, 8), followed by an output register.

Parameters:
- W, 11, data width of in/out (fixed at 11 for this block; stage logic must not assume other widths work).
- SW, 4, width of shift-amount input sel.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies in/sel this cycle
- in  input  11  mantissa to shift
- sel  input  4  right-shift amount, 0..15
- out_valid  output  1  registered copy of in_valid
- out  output  11  in >> sel, zero-filled, registered
- sticky  output  1  OR of all bits of in shifted out, registered

Behaviour:
- Reset:
  - rst_n low asynchronously clears out, sticky and out_valid to 0, regardless of clk.
  - Release is synchronous to the next clk edge.
- Datapath is purely combinational from in/sel into four cascaded stages l0..l3:
  - l0 = sel[0] ? in>>1 : in
  - l1 = sel[1] ? l0>>2 : l0
  - l2 = sel[2] ? l1>>4 : l1
  - l3 = sel[3] ? l2>>8 : l2
  - Vacated MSBs are filled with 0 (logical shift, no sign extension).
- Sticky is accumulated per stage:
  - each stage ORs in the bits it drops, i.e. the low 1/2/4/8 bits of its input when its sel bit is set;
  - sticky = OR of all four stage contributions.
- Registering and latency:
  - On each rising clk with rst_n high and in_valid=1: out<=l3, sticky<=accumulated sticky, out_valid<=1.
  - With in_valid=0: out and sticky hold their previous values; out_valid<=0.
  - Latency is exactly 1 cycle, throughput 1 per cycle, no backpressure.
- Boundary conditions:
  - sel=0: out=in, sticky=0.
  - sel>=11 (11..15): out=0; sticky = (in != 0).
  - in=0: out=0, sticky=0 for any sel.
  - sel changing every cycle: each sample is independent; there is no state besides the output register.
  - Reset asserted mid-stream: any in-flight result is discarded; after release, the first out_valid appears one cycle after the first in_valid sampled high.
- Internal stage l3 is a named net so benches can probe the pre-register result.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out nonzero -> out=0, sticky=0, out_valid=0 immediately, without waiting for a clk edge.
- in=11110111011, sel=0110, in_valid=1 -> next cycle out=00000011110, sticky=1, out_valid=1; l3 shows 00000011110 combinationally.
- in=11110111011, sel=1001 -> out=00000000011, sticky=1; then sel=0000 -> out=11110111011, sticky=0.
- in=10000000000, sel=1010 -> out=00000000001, sticky=0; sel=1011 -> out=0, sticky=1; sel=1111 -> out=0, sticky=1.
- Sweep sel 0..15 for in=00000000001 and in=11111111111 -> compare against a reference model of in>>sel and (in & ((1<<sel)-1))!=0, checking every cycle.
- in_valid toggling: drop in_valid for 2 cycles while changing in -> out/sticky hold, out_valid=0 for those cycles; resume -> new result after 1 cycle.

Source files
------------

// File: rtl/r_shifter.sv
// r_shifter: registered 11-bit logical right barrel shifter with sticky-bit output
module r_shifter #(
  parameter int W  = 11,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in,
  input  logic [SW-1:0] sel,
  output logic          out_valid,
  output logic [W-1:0]  out,
  output logic          sticky
);
  logic [W-1:0] l0, l1, l2, l3;
  logic s0, s1, s2, s3;
  // each stage contributes the low bits it discards
  assign l0 = sel[0] ? in >> 1 : in;
  assign s0 = sel[0] & in[0];
  assign l1 = sel[1] ? l0 >> 2 : l0;
  assign s1 = sel[1] & |l0[1:0];
  assign l2 = sel[2] ? l1 >> 4 : l1;
  assign s2 = sel[2] & |l1[3:0];
  assign l3 = sel[3] ? l2 >> 8 : l2;
  assign s3 = sel[3] & |l2[7:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out    <= l3;
        sticky <= s0 | s1 | s2 | s3;
      end
    end
endmodule

// File: tb/tb_r_shifter.sv
// tb_r_shifter: directed self-checking bench for r_shifter
module tb_r_shifter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [10:0] din = '0;
  logic [3:0]  sh = '0;
  logic        out_valid;
  logic [10:0] out;
  logic        sticky;
  int tests = 0;
  int fails = 0;
  r_shifter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in(din), .sel(sh),
    .out_valid(out_valid), .out(out), .sticky(sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [10:0] i, input logic [3:0] s, input logic v);
    din = i;
    sh = s;
    valid = v;
    #1;
    if (v) chk("l3", {21'd0, dut.l3}, {21'd0, ref_out(i, s)});
    @(posedge clk);
    #1;
  endtask
  function automatic logic [10:0] ref_out(input logic [10:0] i, input logic [3:0] s);
    int x;
    x = int'(i) >> s;
    return x[10:0];
  endfunction
  function automatic logic ref_st(input logic [10:0] i, input logic [3:0] s);
    return (int'(i) & ((1 << s) - 1)) != 0;
  endfunction
  task automatic expect_out(input string tag, input logic [10:0] o, input logic st, input logic v);
    chk({tag, ".out"}, {21'd0, out}, {21'd0, o});
    chk({tag, ".sticky"}, {31'd0, sticky}, {31'd0, st});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1 expect_out("rst0", 11'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(11'b11110111011, 4'b0110, 1'b1);
    expect_out("v1", 11'b00000011110, 1'b1, 1'b1);
    step(11'b11110111011, 4'b1001, 1'b1);
    expect_out("v2", 11'b00000000011, 1'b1, 1'b1);
    step(11'b11110111011, 4'b0000, 1'b1);
    expect_out("v3", 11'b11110111011, 1'b0, 1'b1);
    // asynchronous reset mid-cycle while out is nonzero
    #2 rst_n = 1'b0;
    #1 expect_out("arst", 11'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(11'b10101010101, 4'b0001, 1'b0);
    expect_out("post_rst_idle", 11'd0, 1'b0, 1'b0);
    step(11'b10000000000, 4'b1010, 1'b1);
    expect_out("v4", 11'b00000000001, 1'b0, 1'b1);
    step(11'b10000000000, 4'b1011, 1'b1);
    expect_out("v5", 11'd0, 1'b1, 1'b1);
    step(11'b10000000000, 4'b1111, 1'b1);
    expect_out("v6", 11'd0, 1'b1, 1'b1);
    for (int s = 0; s < 16; s++) begin
      step(11'd0, 4'(s), 1'b1);
      expect_out($sformatf("zero_s%0d", s), 11'd0, 1'b0, 1'b1);
    end
    for (int s = 0; s < 16; s++) begin
      step(11'd1, 4'(s), 1'b1);
      expect_out($sformatf("one_s%0d", s), ref_out(11'd1, 4'(s)), ref_st(11'd1, 4'(s)), 1'b1);
    end
    for (int s = 0; s < 16; s++) begin
      step(11'h7ff, 4'(s), 1'b1);
      expect_out($sformatf("ones_s%0d", s), ref_out(11'h7ff, 4'(s)), ref_st(11'h7ff, 4'(s)), 1'b1);
    end
    step(11'b01101100101, 4'b0011, 1'b1);
    expect_out("pre_hold", 11'b00001101100, 1'b1, 1'b1);
    step(11'b11111111111, 4'b0101, 1'b0);
    expect_out("hold1", 11'b00001101100, 1'b1, 1'b0);
    step(11'b00000010000, 4'b0000, 1'b0);
    expect_out("hold2", 11'b00001101100, 1'b1, 1'b0);
    step(11'b00000010000, 4'b0100, 1'b1);
    expect_out("resume", 11'b00000000001, 1'b0, 1'b1);
    step(11'b00000010000, 4'b0100, 1'b0);
    expect_out("resume_idle", 11'b00000000001, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
